issue_operand: RTL and testbench
================================

# issue_operand

In-order issue stage of the DHRUT-V pipeline, sitting between decode and the ALU/LSU stages.
- Accepts one decoded `uop_t` per cycle and reads both source operands from the architectural register file (ARF).
- Resolves each operand against the execute-stage and retire-stage forwarding buses.
- Detects load-use hazards and stalls decode until they clear.
- Holds the issued uop and operand values in a registered, stallable output slot.
- Consumes the retire stage's operand-forward bus; forwarding from retire is always combinational.

## Interface
Parameters:
- `XLEN`, 32, operand width
- `CNT_W`, 32, width of the hazard-stall performance counter

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `i_dec_valid`  in  1  decode presents a uop
- `i_dec_uop`  in  uop_t  decoded uop (uses `rs1`, `rs2`, `rd`, `uses_rs1`, `uses_rs2`, `writes_rd`, `is_load`)
- `o_dec_ready`  out  1  issue accepts the decode uop this cycle
- `o_rf_rs1_addr` / `o_rf_rs2_addr`  out  5  ARF read addresses; always equal to `i_dec_uop.rs1` / `i_dec_uop.rs2`
- `i_rf_rs1_data` / `i_rf_rs2_data`  in  XLEN  ARF asynchronous read data
- `i_ex_fwd_valid`  in  1  execute stage holds a valid uop
- `i_ex_fwd_rd`  in  5  destination register of the execute-stage uop
- `i_ex_fwd_writes_rd`  in  1  execute-stage uop writes `rd`
- `i_ex_fwd_is_load`  in  1  execute-stage uop is a load, so its result is not yet available
- `i_ex_fwd_result`  in  XLEN  execute-stage result
- `i_retire_fwd_rd`, `i_retire_fwd_writes_rd`, `i_retire_fwd_result`  in  5/1/XLEN  retire forward bus; an invalid retire slot has `writes_rd` = 0
- `i_flush`  in  1  pipeline flush
- `i_iss_ready`  in  1  downstream accepts the issue slot
- `o_iss_valid`  out  1  issue slot valid
- `o_iss_uop`  out  uop_t  issued uop
- `o_iss_rs1_val` / `o_iss_rs2_val`  out  XLEN  resolved operand values
- `o_hazard_stalls`  out  CNT_W  count of load-use stall cycles

## Operation
**Operand resolution** (combinational, per source, first match wins):
1. Source index is 0 → value 0.
2. `i_ex_fwd_valid` && `i_ex_fwd_writes_rd` && `i_ex_fwd_rd` == src && !`i_ex_fwd_is_load` → `i_ex_fwd_result`.
3. `i_retire_fwd_writes_rd` && `i_retire_fwd_rd` == src → `i_retire_fwd_result`.
4. Otherwise → ARF read data.
- Retire must override the ARF because the ARF write occurs in the same cycle; the ARF does not bypass internally.

**Hazard:**
- `hazard` = `i_dec_valid` && `i_ex_fwd_valid` && `i_ex_fwd_is_load` && `i_ex_fwd_writes_rd` && `i_ex_fwd_rd` != 0 && ((`uses_rs1` && `rs1` == `i_ex_fwd_rd`) || (`uses_rs2` && `rs2` == `i_ex_fwd_rd`)).
- A source whose `uses_rsN` = 0 never raises a hazard.

**Control:**
- `advance` = !`o_iss_valid` || `i_iss_ready`.
- `o_dec_ready` = !`i_flush` && !`hazard` && `advance`.
- On `advance` && !`i_flush`:
  - The slot loads `valid` = `i_dec_valid` && !`hazard`, together with the uop and resolved operands.
  - When the loaded valid is 0, the uop and operands are zeroed.
- When not advancing, the slot holds its contents; captured operands remain correct because they were resolved at capture time.

**FSM** (`RUN`, `LU_STALL`), observable only through the counter:
- `RUN` → `LU_STALL` when `hazard` && !`i_flush`.
- `LU_STALL` → `RUN` when !`hazard` or `i_flush`.
- `o_hazard_stalls` increments by 1 in every cycle where `hazard` && !`i_flush`; it wraps modulo 2^CNT_W and is not cleared by flush.

**Flush:**
- Synchronously clears the slot (`valid`, uop and operands = 0) and forces the FSM to `RUN`.
- `o_dec_ready` is 0 during a flush cycle.
- Flush has priority over advance, hazard and `i_iss_ready`.

## Timing
- Reset values: `o_iss_valid` = 0, `o_iss_uop` = '0, operands = 0, `o_hazard_stalls` = 0, FSM = `RUN`.
- Latency: a uop accepted at edge N is presented on the outputs from edge N onward; 1 cycle from decode to execute.
- Throughput: 1 uop per cycle with no hazards and `i_iss_ready` = 1.
- Load-use stall is exactly one cycle: the load moves to retire, and the dependent uop is then captured with the retire-forwarded value.
- Downstream stall (`i_iss_ready` = 0 while `o_iss_valid` = 1): `o_dec_ready` = 0 and outputs are stable.
- Reset asserted mid-stall clears everything asynchronously.
- Hazard and flush in the same cycle: flush wins and the counter does not increment.

## Structure
- `riscv_uop_pkg` owns `uop_t`; this block requires it to contain `uses_rs1`, `uses_rs2` and `is_load`.
- The package also owns the `iss_state_e` enum (`RUN`, `LU_STALL`).
- One sub-module, `operand_fwd_mux`, is instantiated twice (once for rs1, once for rs2) and implements the four-level priority select.

## Test plan
- Back-to-back independent ALU uops with `i_iss_ready` = 1 → one issue per cycle, operands taken from ARF, `o_hazard_stalls` = 0.
- EX uop writes x5 = 0xAAAA_0001 and retire writes x5 = 0x1111; next uop reads x5 → rs1_val = 0xAAAA_0001 (execute beats retire).
- Load in EX to x7 with dependent `add x8, x7, x7` → `o_dec_ready` = 0 for one cycle, counter = 1, then issue with retire-forwarded value 0x0000_BEEF on both operands.
- A uop with rd/rs = x0 while a forward bus targets x0 with value 0xFFFF_FFFF → operand = 0 and no hazard.
- Slot valid with `i_iss_ready` = 0 for 3 cycles → outputs stable and `o_dec_ready` = 0; assert `i_flush` → next cycle `o_iss_valid` = 0 and the FSM is back in `RUN`.
- Hazard and `i_flush` in the same cycle → counter unchanged and slot cleared; deasserting `rst_n` mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/riscv_uop_pkg.sv
// Shared uop definition and issue-stage types for the DHRUT-V pipeline.
package riscv_uop_pkg;

   localparam int REG_AW = 5;

   // Decoded micro-op as handed from decode to issue and on to execute.
   typedef struct packed {
      logic [6:0]        opcode;
      logic [2:0]        funct3;
      logic [31:0]       imm;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              uses_rs1;
      logic              uses_rs2;
      logic              writes_rd;
      logic              is_load;
   } uop_t;

   // Issue-stage control state; RUN is the normal flow state.
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } iss_state_e;

   // A source that is actually read and names the given non-zero register.
   function automatic logic src_hits(input logic              used,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
      return used && (src == dst);
   endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-source operand select: x0, execute forward, retire forward, then ARF.
module operand_fwd_mux
   import riscv_uop_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic              ex_valid_i,
   input  logic              ex_writes_rd_i,
   input  logic              ex_is_load_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [XLEN-1:0]   ex_result_i,
   input  logic              rt_writes_rd_i,
   input  logic [REG_AW-1:0] rt_rd_i,
   input  logic [XLEN-1:0]   rt_result_i,
   input  logic [XLEN-1:0]   rf_data_i,
   output logic [XLEN-1:0]   val_o
);

   logic src_zero;
   logic ex_hit;
   logic rt_hit;

   assign src_zero = (src_i == '0);
   // A load in execute has no result yet; the hazard logic stalls those cases.
   assign ex_hit   = ex_valid_i && ex_writes_rd_i && !ex_is_load_i && (ex_rd_i == src_i);
   // Retire writes the ARF this same cycle and the ARF does not bypass itself.
   assign rt_hit   = rt_writes_rd_i && (rt_rd_i == src_i);

   // Priority select, youngest producer first.
   always_comb begin
      val_o = rf_data_i;
      if (src_zero)
         val_o = '0;
      else if (ex_hit)
         val_o = ex_result_i;
      else if (rt_hit)
         val_o = rt_result_i;
   end

endmodule

// File: rtl/issue_operand.sv
// In-order issue stage: operand read/forward, load-use stall, registered issue slot.
module issue_operand
   import riscv_uop_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_dec_valid,
   input  uop_t              i_dec_uop,
   output logic              o_dec_ready,
   output logic [REG_AW-1:0] o_rf_rs1_addr,
   output logic [REG_AW-1:0] o_rf_rs2_addr,
   input  logic [XLEN-1:0]   i_rf_rs1_data,
   input  logic [XLEN-1:0]   i_rf_rs2_data,
   input  logic              i_ex_fwd_valid,
   input  logic [REG_AW-1:0] i_ex_fwd_rd,
   input  logic              i_ex_fwd_writes_rd,
   input  logic              i_ex_fwd_is_load,
   input  logic [XLEN-1:0]   i_ex_fwd_result,
   input  logic [REG_AW-1:0] i_retire_fwd_rd,
   input  logic              i_retire_fwd_writes_rd,
   input  logic [XLEN-1:0]   i_retire_fwd_result,
   input  logic              i_flush,
   input  logic              i_iss_ready,
   output logic              o_iss_valid,
   output uop_t              o_iss_uop,
   output logic [XLEN-1:0]   o_iss_rs1_val,
   output logic [XLEN-1:0]   o_iss_rs2_val,
   output logic [CNT_W-1:0]  o_hazard_stalls
);

   iss_state_e        state_q, state_d;
   logic              valid_q, valid_d;
   uop_t              uop_q, uop_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              cnt_inc;

   logic              hazard;
   logic              advance;
   logic              ld_valid;
   logic              ex_load_pending;
   logic [XLEN-1:0]   rs1_res;
   logic [XLEN-1:0]   rs2_res;

   // ARF is read directly with the decode sources; no translation here.
   assign o_rf_rs1_addr = i_dec_uop.rs1;
   assign o_rf_rs2_addr = i_dec_uop.rs2;

   operand_fwd_mux #(.XLEN(XLEN)) u_rs1_mux (
      .src_i          (i_dec_uop.rs1),
      .ex_valid_i     (i_ex_fwd_valid),
      .ex_writes_rd_i (i_ex_fwd_writes_rd),
      .ex_is_load_i   (i_ex_fwd_is_load),
      .ex_rd_i        (i_ex_fwd_rd),
      .ex_result_i    (i_ex_fwd_result),
      .rt_writes_rd_i (i_retire_fwd_writes_rd),
      .rt_rd_i        (i_retire_fwd_rd),
      .rt_result_i    (i_retire_fwd_result),
      .rf_data_i      (i_rf_rs1_data),
      .val_o          (rs1_res)
   );

   operand_fwd_mux #(.XLEN(XLEN)) u_rs2_mux (
      .src_i          (i_dec_uop.rs2),
      .ex_valid_i     (i_ex_fwd_valid),
      .ex_writes_rd_i (i_ex_fwd_writes_rd),
      .ex_is_load_i   (i_ex_fwd_is_load),
      .ex_rd_i        (i_ex_fwd_rd),
      .ex_result_i    (i_ex_fwd_result),
      .rt_writes_rd_i (i_retire_fwd_writes_rd),
      .rt_rd_i        (i_retire_fwd_rd),
      .rt_result_i    (i_retire_fwd_result),
      .rf_data_i      (i_rf_rs2_data),
      .val_o          (rs2_res)
   );

   // A load in execute to a real register blocks any uop that reads it;
   // one cycle later the load sits on the retire bus and forwards from there.
   assign ex_load_pending = i_ex_fwd_valid && i_ex_fwd_is_load && i_ex_fwd_writes_rd
                            && (i_ex_fwd_rd != '0);
   assign hazard  = i_dec_valid && ex_load_pending
                    && (src_hits(i_dec_uop.uses_rs1, i_dec_uop.rs1, i_ex_fwd_rd)
                     || src_hits(i_dec_uop.uses_rs2, i_dec_uop.rs2, i_ex_fwd_rd));

   assign advance     = !valid_q || i_iss_ready;
   assign ld_valid    = i_dec_valid && !hazard;
   assign o_dec_ready = !i_flush && !hazard && advance;

   // Next slot contents: flush clears, advance captures (zeroed when empty), else hold.
   always_comb begin
      valid_d = valid_q;
      uop_d   = uop_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      if (i_flush) begin
         valid_d = 1'b0;
         uop_d   = '0;
         rs1_d   = '0;
         rs2_d   = '0;
      end else if (advance) begin
         valid_d = ld_valid;
         uop_d   = ld_valid ? i_dec_uop : '0;
         rs1_d   = ld_valid ? rs1_res   : '0;
         rs2_d   = ld_valid ? rs2_res   : '0;
      end
   end

   // Issue slot register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         uop_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
      end else begin
         valid_q <= valid_d;
         uop_q   <= uop_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   // FSM next state: enter LU_STALL on a live hazard, leave when it clears or on flush.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (hazard && !i_flush) state_d = LU_STALL;
         LU_STALL: if (!hazard || i_flush) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   // FSM output: every cycle spent stalling on a load-use counts, flush cycles do not.
   always_comb begin
      cnt_inc = hazard && !i_flush;
   end

   // Stall performance counter; wraps naturally and survives flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (cnt_inc)
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign o_iss_valid     = valid_q;
   assign o_iss_uop       = uop_q;
   assign o_iss_rs1_val   = rs1_q;
   assign o_iss_rs2_val   = rs2_q;
   assign o_hazard_stalls = cnt_q;

endmodule

// File: tb/tb_issue_operand.sv
// Directed + random bench for issue_operand against a behavioural slot model.
module tb_issue_operand;
   import riscv_uop_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        dec_valid;
   uop_t        dec_uop;
   logic        dec_ready;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        ex_valid, ex_wr, ex_ld;
   logic [4:0]  ex_rd;
   logic [31:0] ex_res;
   logic [4:0]  rt_rd;
   logic        rt_wr;
   logic [31:0] rt_res;
   logic        flush, iss_ready;
   logic        iss_valid;
   uop_t        iss_uop;
   logic [31:0] iss_rs1, iss_rs2;
   logic [31:0] stalls;

   logic [31:0] rf [32];

   int          tests = 0;
   int          fails = 0;

   // behavioural model of the issue slot
   logic        m_valid;
   uop_t        m_uop;
   logic [31:0] m_rs1, m_rs2;
   int unsigned m_cnt;
   logic        e_haz, e_ready;

   issue_operand #(.XLEN(32), .CNT_W(32)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .i_dec_valid            (dec_valid),
      .i_dec_uop              (dec_uop),
      .o_dec_ready            (dec_ready),
      .o_rf_rs1_addr          (rs1_addr),
      .o_rf_rs2_addr          (rs2_addr),
      .i_rf_rs1_data          (rs1_data),
      .i_rf_rs2_data          (rs2_data),
      .i_ex_fwd_valid         (ex_valid),
      .i_ex_fwd_rd            (ex_rd),
      .i_ex_fwd_writes_rd     (ex_wr),
      .i_ex_fwd_is_load       (ex_ld),
      .i_ex_fwd_result        (ex_res),
      .i_retire_fwd_rd        (rt_rd),
      .i_retire_fwd_writes_rd (rt_wr),
      .i_retire_fwd_result    (rt_res),
      .i_flush                (flush),
      .i_iss_ready            (iss_ready),
      .o_iss_valid            (iss_valid),
      .o_iss_uop              (iss_uop),
      .o_iss_rs1_val          (iss_rs1),
      .o_iss_rs2_val          (iss_rs2),
      .o_hazard_stalls        (stalls)
   );

   assign rs1_data = rf[rs1_addr];
   assign rs2_data = rf[rs2_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Operand value a reader of register s should see this cycle.
   function automatic logic [31:0] resolve(input logic [4:0] s);
      if (s == 5'd0) return 32'h0;
      if (ex_valid && ex_wr && !ex_ld && ex_rd == s) return ex_res;
      if (rt_wr && rt_rd == s) return rt_res;
      return rf[s];
   endfunction

   function automatic uop_t mk_uop(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic u1, input logic u2);
      uop_t u;
      u = '0;
      u.opcode    = 7'h33;
      u.imm       = $urandom;
      u.rd        = rd;
      u.rs1       = rs1;
      u.rs2       = rs2;
      u.uses_rs1  = u1;
      u.uses_rs2  = u2;
      u.writes_rd = 1'b1;
      return u;
   endfunction

   task automatic idle_buses();
      ex_valid = 0; ex_wr = 0; ex_ld = 0; ex_rd = 0; ex_res = 0;
      rt_wr = 0; rt_rd = 0; rt_res = 0;
      flush = 0;
   endtask

   task automatic model_reset();
      m_valid = 0; m_uop = '0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
   endtask

   // One clock: called just after a falling edge with inputs already driven.
   task automatic cycle();
      logic [31:0] r1, r2;
      #1;
      e_haz = dec_valid && ex_valid && ex_ld && ex_wr && ex_rd != 0
              && ((dec_uop.uses_rs1 && dec_uop.rs1 == ex_rd)
               || (dec_uop.uses_rs2 && dec_uop.rs2 == ex_rd));
      e_ready = !flush && !e_haz && (!m_valid || iss_ready);
      chk("dec_ready", 64'(dec_ready), 64'(e_ready));
      chk("rf_addr", 64'({rs1_addr, rs2_addr}), 64'({dec_uop.rs1, dec_uop.rs2}));
      r1 = resolve(dec_uop.rs1);
      r2 = resolve(dec_uop.rs2);
      @(posedge clk);
      #1;
      if (flush) begin
         m_valid = 0; m_uop = '0; m_rs1 = 0; m_rs2 = 0;
      end else if (!m_valid || iss_ready) begin
         m_valid = dec_valid && !e_haz;
         m_uop   = m_valid ? dec_uop : '0;
         m_rs1   = m_valid ? r1 : 32'h0;
         m_rs2   = m_valid ? r2 : 32'h0;
      end
      if (e_haz && !flush) m_cnt++;
      chk("iss_valid", 64'(iss_valid), 64'(m_valid));
      chk("iss_uop", 64'(iss_uop), 64'(m_uop));
      chk("rs1_val", 64'(iss_rs1), 64'(m_rs1));
      chk("rs2_val", 64'(iss_rs2), 64'(m_rs2));
      chk("stalls", 64'(stalls), 64'(m_cnt));
      @(negedge clk);
   endtask

   initial begin
      uop_t saved;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rst_n = 0; dec_valid = 0; dec_uop = '0; iss_ready = 1;
      idle_buses();
      model_reset();
      #12;
      chk("rst_valid", 64'(iss_valid), 64'd0);
      chk("rst_uop", 64'(iss_uop), 64'd0);
      chk("rst_ops", 64'({iss_rs1, iss_rs2}), 64'd0);
      chk("rst_stalls", 64'(stalls), 64'd0);
      @(negedge clk);
      rst_n = 1;

      // back-to-back independent ALU uops straight from the ARF
      for (int i = 0; i < 4; i++) begin
         dec_valid = 1;
         dec_uop   = mk_uop(5'(10 + i), 5'(1 + i), 5'(20 + i), 1, 1);
         cycle();
         chk("b2b_rs1_arf", 64'(iss_rs1), 64'(rf[1 + i]));
      end
      chk("b2b_no_stall", 64'(stalls), 64'd0);

      // execute forward beats retire forward
      ex_valid = 1; ex_wr = 1; ex_rd = 5; ex_res = 32'hAAAA_0001;
      rt_wr = 1; rt_rd = 5; rt_res = 32'h0000_1111;
      dec_uop = mk_uop(6, 5, 5, 1, 1);
      cycle();
      chk("ex_beats_rt", 64'(iss_rs1), 64'h0000_0000_AAAA_0001);
      idle_buses();

      // load-use: one stall, then retire forward supplies both operands
      ex_valid = 1; ex_wr = 1; ex_ld = 1; ex_rd = 7; ex_res = 32'hDEAD_DEAD;
      dec_uop = mk_uop(8, 7, 7, 1, 1);
      cycle();
      chk("lu_cnt", 64'(stalls), 64'd1);
      idle_buses();
      rt_wr = 1; rt_rd = 7; rt_res = 32'h0000_BEEF;
      cycle();
      chk("lu_fwd", 64'({iss_rs1, iss_rs2}), 64'h0000_BEEF_0000_BEEF);
      idle_buses();

      // x0 never forwards and a load to x0 never stalls
      ex_valid = 1; ex_wr = 1; ex_ld = 1; ex_rd = 0; ex_res = 32'hFFFF_FFFF;
      rt_wr = 1; rt_rd = 0; rt_res = 32'hFFFF_FFFF;
      dec_uop = mk_uop(0, 0, 0, 1, 1);
      cycle();
      chk("x0_ops", 64'({iss_rs1, iss_rs2}), 64'd0);
      ex_ld = 0;
      cycle();
      chk("x0_ops_ex", 64'({iss_rs1, iss_rs2}), 64'd0);
      idle_buses();

      // downstream stall holds the slot, then flush empties it
      dec_uop = mk_uop(3, 4, 9, 1, 1);
      cycle();
      saved = iss_uop;
      iss_ready = 0;
      for (int i = 0; i < 3; i++) begin
         dec_uop = mk_uop(5'(11 + i), 5'(2 + i), 5'(3 + i), 1, 1);
         cycle();
         chk("hold_uop", 64'(iss_uop), 64'(saved));
      end
      flush = 1;
      cycle();
      chk("flush_valid", 64'(iss_valid), 64'd0);
      flush = 0; iss_ready = 1;

      // hazard together with flush: no count, slot cleared
      ex_valid = 1; ex_wr = 1; ex_ld = 1; ex_rd = 12;
      dec_uop = mk_uop(13, 12, 1, 1, 1);
      flush = 1;
      cycle();
      chk("haz_flush_cnt", 64'(stalls), 64'd1);
      idle_buses();
      // unused source matching a pending load raises no hazard
      ex_valid = 1; ex_wr = 1; ex_ld = 1; ex_rd = 12;
      dec_uop = mk_uop(13, 12, 12, 0, 0);
      cycle();
      idle_buses();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rf[$urandom_range(1, 7)] = $urandom;
         dec_valid = ($urandom_range(0, 3) != 0);
         dec_uop   = mk_uop(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
         ex_valid  = 1'($urandom);
         ex_wr     = ($urandom_range(0, 3) != 0);
         ex_ld     = ($urandom_range(0, 2) == 0);
         ex_rd     = 5'($urandom_range(0, 7));
         ex_res    = $urandom;
         rt_wr     = 1'($urandom);
         rt_rd     = 5'($urandom_range(0, 7));
         rt_res    = $urandom;
         flush     = ($urandom_range(0, 15) == 0);
         iss_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      // asynchronous reset in the middle of a stalled slot
      idle_buses();
      iss_ready = 0; dec_valid = 1;
      dec_uop = mk_uop(2, 3, 4, 1, 1);
      cycle();
      ex_valid = 1; ex_wr = 1; ex_ld = 1; ex_rd = 3;
      #2;
      rst_n = 0;
      #1;
      chk("arst_valid", 64'(iss_valid), 64'd0);
      chk("arst_uop", 64'(iss_uop), 64'd0);
      chk("arst_ops", 64'({iss_rs1, iss_rs2}), 64'd0);
      chk("arst_stalls", 64'(stalls), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      idle_buses();
      iss_ready = 1;
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
